// File: rtl/conv_pkg.sv
// Shared definitions for the streaming FIR block.
// State encoding and width helpers.
package conv_pkg;

    localparam logic ST_FILL = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        FILL = ST_FILL,
        RUN  = ST_RUN
    } conv_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Accumulator width wide enough that the tap sum never wraps.
    function automatic int acc_w(input int dw, input int cw, input int taps);
        return dw + cw + clog2(taps);
    endfunction

endpackage

// File: rtl/conv_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation.
// The parent registers the result.
module conv_round_sat #(
    parameter int IN_W  = 26,
    parameter int OUT_W = 13,
    parameter int SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);

    localparam int EW = IN_W + 1;
    localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EW-1:0] ONE  = 1;
    localparam logic signed [EW-1:0] HALF = (SHIFT > 0) ? (ONE <<< HS) : '0;
    localparam logic signed [EW-1:0] MAXV = (ONE <<< (OUT_W - 1)) - ONE;
    localparam logic signed [EW-1:0] MINV = -MAXV - ONE;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] shf;

    // Extra headroom bit keeps the rounding add from wrapping.
    always_comb begin
        ext  = EW'(din);
        rnd  = ext + HALF;
        shf  = rnd >>> SHIFT;
        dout = shf[OUT_W-1:0];
        ovf  = 1'b0;
        if (shf > MAXV) begin
            dout = MAXV[OUT_W-1:0];
            ovf  = 1'b1;
        end else if (shf < MINV) begin
            dout = MINV[OUT_W-1:0];
            ovf  = 1'b1;
        end
    end

endmodule

// File: rtl/conv_fir_stream.sv
// Streaming FIR: y[n] = sum h[k]*x[n-k], three-stage pipeline.
// Products, tap sum, then scale/saturate.
module conv_fir_stream
    import conv_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int COEF_W = 12,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 13,
    parameter int SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      coef_we,
    input  logic [clog2(TAPS)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]         coef_data,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_ovf,
    output logic                      filled
);

    localparam int AW    = clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);

    conv_state_t state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic take;

    logic signed [DATA_W-1:0] x   [TAPS];
    logic signed [DATA_W-1:0] x_n [TAPS];
    logic signed [COEF_W-1:0] h   [TAPS];
    logic signed [PW-1:0]     p   [TAPS];
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc;
    logic                     v1, v2;
    logic signed [OUT_W-1:0]  rs_data;
    logic                     rs_ovf;

    // Fill state and sample counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Only the sample that completes the fill, and later ones, are tagged.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        take    = 1'b0;
        unique case (state)
            FILL: begin
                if (in_valid) begin
                    if (cnt == AW'(TAPS - 1)) begin
                        state_n = RUN;
                        take    = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            RUN: take = in_valid;
        endcase
    end

    assign filled = (state == RUN);

    // Delay line as it will look after this edge's shift.
    always_comb begin
        x_n[0] = $signed(in_data);
        for (int k = 1; k < TAPS; k++) x_n[k] = x[k-1];
    end

    // Delay line shift and coefficient writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x[k] <= '0;
                h[k] <= '0;
            end
        end else begin
            if (in_valid) x <= x_n;
            if (coef_we && int'(coef_addr) < TAPS)
                h[coef_addr] <= $signed(coef_data);
        end
    end

    // S1: products use current coefficients, so a same-edge write
    // only affects later samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) p[k] <= '0;
            v1 <= 1'b0;
        end else begin
            for (int k = 0; k < TAPS; k++)
                p[k] <= PW'(x_n[k]) * PW'(h[k]);
            v1 <= take;
        end
    end

    // Sign-extended sum of all tap products.
    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) sum = sum + ACC_W'(p[k]);
    end

    // S2: register the tap sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            v2  <= 1'b0;
        end else begin
            acc <= sum;
            v2  <= v1;
        end
    end

    conv_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_rs (
        .din  (acc),
        .dout (rs_data),
        .ovf  (rs_ovf)
    );

    // S3: outputs hold their last value across gaps.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                out_data <= rs_data;
                out_ovf  <= rs_ovf;
            end
        end
    end

endmodule
